mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Data-memory access stage between execute and the load data mask stage.
//  - Accepts one load/store request at a time.
//  - Builds the word-aligned address, replicated store data and byte enables.
//  - Runs the valid/ready request handshake and the rvalid response handshake with data memory.
//  - Registers the raw load word with its funct3 and byte offset for the downstream mask.
// PARAMETERS
//  DATA_WIDTH  32  data path width; byte-enable width is DATA_WIDTH/8 (only 32 supported)
//  ADDR_WIDTH  32  byte address width
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           reset, asynchronous, active-high
//  req_valid      in   1           pipeline request present
//  req_ready      out  1           unit can accept a request (=state IDLE and !rst)
//  req_we         in   1           1=store, 0=load
//  req_func       in   3           RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr       in   ADDR_WIDTH  byte address
//  req_wdata      in   DATA_WIDTH  store source (rs2)
//  mem_valid      out  1           request to memory
//  mem_ready      in   1           memory accepts request
//  mem_we         out  1           write request
//  mem_addr       out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2],2'b00}
//  mem_wdata      out  DATA_WIDTH  replicated store data
//  mem_wbe        out  4           byte write enables (0 for loads)
//  mem_rvalid     in   1           load data valid
//  mem_rdata      in   DATA_WIDTH  load word
//  rsp_valid      out  1           1-cycle pulse: load result ready
//  rsp_data       out  DATA_WIDTH  raw load word (unmasked)
//  rsp_func       out  3           funct3 of the completed load
//  rsp_byte_addr  out  2           req_addr[1:0] of the completed load
//  stall          out  1           =(state!=IDLE); holds the pipeline
// BEHAVIOUR
//  Reset values: state IDLE; mem_valid, mem_we, rsp_valid 0; mem_wbe 0; all data/addr regs 0.
//  FSM:
//   - IDLE: on req_valid, latch we/func/addr/wdata and go to ISSUE.
//   - ISSUE: mem_valid=1; payload held stable until mem_ready. On the handshake a store goes to IDLE; a load goes to WAIT.
//   - WAIT: on mem_rvalid, capture rdata/func/byte_addr, pulse rsp_valid next cycle, go to IDLE.
//  Store encoding (o = byte offset):
//   - SB: wdata={4{b[7:0]}}, wbe=4'b0001<<o.
//   - SH: wdata={2{b[15:0]}}, wbe=4'b0011<<{o[1],1'b0}.
//   - SW: wdata=b, wbe=4'b1111.
//   - Any other funct3 with we=1: wbe=0.
//  Latency: request accepted in cycle N -> mem_valid in N+1. Load with mem_ready@N+1 and rvalid@N+2 -> rsp_valid@N+3.
//  Stores produce no rsp. Throughput is at most 1 request per 2 cycles.
//  mem_rvalid outside WAIT is ignored. mem_ready outside ISSUE is ignored.
//  req_valid while not IDLE is not accepted; the requester holds the request.
//  Reset mid-operation clears the FSM immediately (async): mem_valid drops, an in-flight response is discarded, no rsp_valid.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//   - A misaligned request is accepted but never reaches memory and no rsp is produced.
//   - Output misalign (1) pulses 1 cycle after acceptance; the FSM returns to IDLE.
//  MISALIGN_TRAP_EN undefined: no misalign port; access silently aligns down (halfwords to addr[1]).
// TESTING
//  1. SW 0xDEADBEEF @0x100, mem_ready=1 -> mem_addr 0x100, wbe 1111, wdata 0xDEADBEEF; back to IDLE in 2 cycles.
//  2. SB 0x12345678 @0x103 -> wbe 1000, wdata 0x78787878. SH @0x102 -> wbe 1100, wdata 0x56785678.
//  3. LBU @0x101, mem_ready delayed 3 cycles, rdata 0xAABBCCDD -> rsp_data 0xAABBCCDD, rsp_func 100, rsp_byte_addr 01, 1-cycle rsp_valid.
//  4. Back-to-back: LW then SW on consecutive cycles -> second accepted only after first's rsp; stall high throughout.
//  5. rst asserted in WAIT, then rvalid -> mem_valid 0 at once, no rsp_valid, req_ready 1 after release.
//  6. With MISALIGN_TRAP_EN: LW @0x102 -> misalign pulse, mem_valid stays 0. Without it: mem_addr 0x100, load completes.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store in flight; builds aligned address, store lanes and byte enables.
// Optional MISALIGN_TRAP_EN: misaligned requests are accepted, never issued, and flagged on the misalign output.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_func,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wbe,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [2:0]              rsp_func,
  output logic [1:0]              rsp_byte_addr,
  output logic                    stall,
`ifdef MISALIGN_TRAP_EN
  output logic                    misalign,
`endif
  output logic [1:0]              dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a memory command transfers where mem_valid && mem_ready; mem_rvalid is a one-cycle data strobe.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [2:0]              func_q;
  logic [1:0]              off_q;
  logic                    mem_valid_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH/8-1:0] mem_wbe_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [2:0]              rsp_func_q;
  logic [1:0]              rsp_byte_addr_q;

  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [DATA_WIDTH/8-1:0] wbe_d;
  logic [1:0]              off;

  always_comb begin
    off     = req_addr[1:0];
    wdata_d = req_wdata;
    wbe_d   = '0;
    if (req_we) begin
      case (req_func)
        3'b000: begin
          wdata_d = {4{req_wdata[7:0]}};
          wbe_d   = 4'b0001 << off;
        end
        3'b001: begin
          wdata_d = {2{req_wdata[15:0]}};
          wbe_d   = 4'b0011 << {off[1], 1'b0};
        end
        3'b010:  wbe_d = 4'b1111;
        default: wbe_d = '0;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  logic misalign_d;
  always_comb begin
    misalign_d = ((req_func == 3'b001) || (!req_we && req_func == 3'b101)) ? off[0] :
                 (req_func == 3'b010) ? (off != 2'b00) : 1'b0;
  end
  assign misalign = misalign_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      func_q          <= '0;
      off_q           <= '0;
      mem_valid_q     <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wbe_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_func_q      <= '0;
      rsp_byte_addr_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q      <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
            if (misalign_d) begin
              misalign_q <= 1'b1;
            end else begin
`endif
              func_q      <= req_func;
              off_q       <= off;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wbe_q   <= wbe_d;
              mem_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
`ifdef MISALIGN_TRAP_EN
            end
`endif
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= mem_we_q ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          // Raw word goes downstream unmasked; the mask stage needs funct3 and offset.
          if (mem_rvalid) begin
            rsp_data_q      <= mem_rdata;
            rsp_func_q      <= func_q;
            rsp_byte_addr_q <= off_q;
            rsp_valid_q     <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign stall         = (state_q != S_IDLE);
  assign mem_valid     = mem_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wbe       = mem_wbe_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_func      = rsp_func_q;
  assign rsp_byte_addr = rsp_byte_addr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized traffic against a byte-lane model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_func;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wbe;
  logic        mem_rvalid;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_func;
  logic [1:0]  rsp_byte_addr;
  logic        stall;
  logic [1:0]  dbg_state;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];

  logic        nxt_we;
  logic [2:0]  nxt_func;
  logic [31:0] nxt_addr, nxt_wdata;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_func(rsp_func),
    .rsp_byte_addr(rsp_byte_addr), .stall(stall),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding load
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e[31:0]);
        check("rsp_byte_addr", rsp_byte_addr, e[33:32]);
        check("rsp_func", rsp_func, e[36:34]);
      end
    end
  end

  // Access size in bytes for a funct3; 0 marks an encoding with no memory effect
  function automatic int access_size(input logic we, input logic [2:0] func);
    if (we && func[2]) return 0;
    case (func[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] func, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_dly, input int rv_dly,
                        input logic [31:0] rdata, input bit keep_next);
    int sz, base;
    logic [3:0]  ewbe;
    logic [31:0] ewd;
    sz   = access_size(we, func);
    base = (sz > 0) ? (int'(addr[1:0]) - (int'(addr[1:0]) % sz)) : 0;
    ewbe = '0;
    ewd  = '0;
    for (int b = 0; b < 4; b++) begin
      if (we && sz > 0 && b >= base && b < base + sz) ewbe[b] = 1'b1;
      if (sz > 0) ewd[b*8 +: 8] = wdata[(b % sz)*8 +: 8];
    end

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_func = func; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    if (keep_next) begin
      req_valid = 1'b1; req_we = nxt_we; req_func = nxt_func;
      req_addr = nxt_addr; req_wdata = nxt_wdata;
    end else begin
      req_valid = 1'b0;
    end

`ifdef MISALIGN_TRAP_EN
    if (sz > 1 && (int'(addr[1:0]) % sz) != 0) begin
      check("misalign_pulse", misalign, 1);
      check("misalign_no_mem", mem_valid, 0);
      check("misalign_no_stall", stall, 0);
      @(negedge clk);
      check("misalign_one_cycle", misalign, 0);
      return;
    end
    check("misalign_quiet", misalign, 0);
`endif

    check("mem_valid", mem_valid, 1);
    check("stall_issue", stall, 1);
    check("mem_we", mem_we, we);
    check("mem_addr", mem_addr, {addr[31:2], 2'b00});
    check("mem_wbe", mem_wbe, ewbe);
    if (we && sz > 0) check("mem_wdata", mem_wdata, ewd);

    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check("hold_valid", mem_valid, 1);
      check("hold_addr", mem_addr, {addr[31:2], 2'b00});
      check("hold_blocked", req_ready, 0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("valid_drop", mem_valid, 0);

    if (we) begin
      check("store_idle", stall, 0);
      return;
    end

    check("load_wait", stall, 1);
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      check("no_early_rsp", rsp_valid, 0);
      check("wait_blocked", req_ready, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    exp_q.push_back({func, addr[1:0], rdata});
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rsp_latency", rsp_valid, 1);
    check("load_idle", stall, 0);
  endtask

  task automatic reset_test();
    // Reset while the command is being offered
    req_valid = 1'b1; req_we = 1'b0; req_func = 3'b010; req_addr = 32'h40; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_valid", mem_valid, 1);
    #2 rst = 1'b1;
    #1 check("rst_issue_valid", mem_valid, 0);
    check("rst_issue_stall", stall, 0);
    check("rst_issue_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    // Reset while waiting for read data; the late data must be dropped
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst_pre_wait", stall, 1);
    #2 rst = 1'b1;
    #1 check("rst_wait_stall", stall, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_no_rsp", rsp_valid, 0);
    check("rst_release_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
  endtask

  initial begin
    logic [2:0] ld_f[5];
    logic [2:0] st_f[4];
    logic       we;
    logic [2:0] f;
    ld_f = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f = '{3'b000, 3'b001, 3'b010, 3'b011};
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    nxt_we = 1'b0; nxt_func = '0; nxt_addr = '0; nxt_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", req_ready, 0);
    check("reset_stall", stall, 0);
    check("reset_mem_valid", mem_valid, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_wbe", mem_wbe, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, '0, 1'b0);
    do_req(1'b1, 3'b000, 32'h103, 32'h12345678, 1, 0, '0, 1'b0);
    do_req(1'b1, 3'b001, 32'h102, 32'h12345678, 0, 0, '0, 1'b0);
    do_req(1'b0, 3'b100, 32'h101, '0, 3, 0, 32'hAABBCCDD, 1'b0);
    nxt_we = 1'b1; nxt_func = 3'b010; nxt_addr = 32'h204; nxt_wdata = 32'hCAFEF00D;
    do_req(1'b0, 3'b010, 32'h200, '0, 1, 2, 32'h01020304, 1'b1);
    do_req(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, '0, 1'b0);
    do_req(1'b0, 3'b010, 32'h102, '0, 0, 0, 32'h55667788, 1'b0);
    reset_test();

    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f  = we ? st_f[$urandom_range(0, 3)] : ld_f[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        check("stray_ignored", stall, 0);
      end
      do_req(we, f, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("all_rsp_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
